// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the peripheral-bus requester:
//   - default bus address / data widths and ACCESS timeout length
//   - transfer FSM state encoding (IDLE / SETUP / ACCESS / RESP)
//   - strb_width(): number of byte strobes for a given data width
// ---------------------------------------------------------------------------
package apb_pkg;

  localparam int APB_ADDR_WIDTH = 32;
  localparam int APB_DATA_WIDTH = 32;
  localparam int APB_TIMEOUT    = 256;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  // One strobe bit per byte lane of the data bus.
  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/apb_timeout.sv
// ---------------------------------------------------------------------------
// apb_timeout
// ACCESS-phase watchdog for apb_requester (only instantiated when the
// APB_TIMEOUT_EN macro is defined).
// Ports:
//   pclk, presetn  bus clock, asynchronous active-low reset
//   clear          restart the count (asserted while in SETUP, i.e. on the
//                  cycle before ACCESS is entered)
//   count_en       one ACCESS cycle has elapsed at this edge
//   expired        high during the TIMEOUT-th ACCESS cycle; if ready is
//                  still low in that cycle the transfer is aborted
// ---------------------------------------------------------------------------
module apb_timeout
  import apb_pkg::*;
#(
  parameter int TIMEOUT = APB_TIMEOUT
) (
  input  logic pclk,
  input  logic presetn,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int              CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          expired_q;
  logic          expired_d;

  // Next count and expiry flag; cnt_q holds (ACCESS cycles completed so far),
  // so the flag is registered against the value the counter is moving to.
  always_comb begin
    cnt_d     = cnt_q;
    expired_d = expired_q;
    if (clear) begin
      cnt_d     = {CW{1'b0}};
      expired_d = (LAST == {CW{1'b0}});
    end else if (count_en) begin
      if (cnt_q != LIMIT) begin
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        cnt_d = cnt_q;
      end
      expired_d = (cnt_d == LAST);
    end else begin
      cnt_d     = cnt_q;
      expired_d = expired_q;
    end
  end

  // Counter and expiry registers.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt_q     <= {CW{1'b0}};
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/apb_requester.sv
// ---------------------------------------------------------------------------
// apb_requester
// Converts single-outstanding core load/store requests into two-phase
// SETUP/ACCESS transfers on the peripheral bus and returns read data and
// error status to the core.
//
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS phase that has
// not seen ready after TIMEOUT cycles (response then carries rsp_err=1,
// rsp_rdata=0). Without the macro ACCESS waits indefinitely.
//
// Ports:
//   pclk, presetn                     clock, asynchronous active-low reset
//   req_valid/req_ready               core request handshake (ready in IDLE)
//   req_addr/req_wdata/req_write/req_stb  request payload
//   rsp_valid/rsp_ready               response handshake
//   rsp_rdata/rsp_err                 captured read data / error
//   paddr/pdata/pwrite/pstb           bus payload, held between transfers
//   psel/penable                      bus phase control
//   prdata/ready/perr                 completer return
// All outputs are registered; ready/perr/prdata reach no output
// combinationally.
// ---------------------------------------------------------------------------
module apb_requester
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH = APB_DATA_WIDTH,
  parameter int TIMEOUT    = APB_TIMEOUT
) (
  input  logic                                pclk,
  input  logic                                presetn,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic [ADDR_WIDTH-1:0]               req_addr,
  input  logic [DATA_WIDTH-1:0]               req_wdata,
  input  logic                                req_write,
  input  logic [strb_width(DATA_WIDTH)-1:0]   req_stb,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [DATA_WIDTH-1:0]               rsp_rdata,
  output logic                                rsp_err,
  output logic [ADDR_WIDTH-1:0]               paddr,
  output logic [DATA_WIDTH-1:0]               pdata,
  input  logic [DATA_WIDTH-1:0]               prdata,
  output logic                                psel,
  output logic                                penable,
  output logic                                pwrite,
  output logic [strb_width(DATA_WIDTH)-1:0]   pstb,
  input  logic                                ready,
  input  logic                                perr
);

  localparam int STB_WIDTH = strb_width(DATA_WIDTH);

  apb_state_e             state_q,     state_d;
  logic [ADDR_WIDTH-1:0]  paddr_q,     paddr_d;
  logic [DATA_WIDTH-1:0]  pdata_q,     pdata_d;
  logic                   pwrite_q,    pwrite_d;
  logic [STB_WIDTH-1:0]   pstb_q,      pstb_d;
  logic                   psel_q,      psel_d;
  logic                   penable_q,   penable_d;
  logic                   req_ready_q, req_ready_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_err_q,   rsp_err_d;
  logic                   timeout_s;

`ifdef APB_TIMEOUT_EN
  apb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .pclk     (pclk),
    .presetn  (presetn),
    .clear    (state_q == ST_SETUP),
    .count_en (state_q == ST_ACCESS),
    .expired  (timeout_s)
  );
`else
  assign timeout_s = 1'b0;
`endif

  // Transfer FSM: next state and next value of every registered output.
  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pdata_d     = pdata_q;
    pwrite_d    = pwrite_q;
    pstb_d      = pstb_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          paddr_d     = req_addr;
          pdata_d     = req_wdata;
          pwrite_d    = req_write;
          // Reads never drive byte strobes.
          pstb_d      = req_write ? req_stb : {STB_WIDTH{1'b0}};
          psel_d      = 1'b1;
          req_ready_d = 1'b0;
          state_d     = ST_SETUP;
        end else begin
          req_ready_d = 1'b1;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        // ready is checked first so it wins over a same-edge timeout.
        if (ready) begin
          rsp_rdata_d = pwrite_q ? {DATA_WIDTH{1'b0}} : prdata;
          rsp_err_d   = perr;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (timeout_s) begin
          rsp_rdata_d = {DATA_WIDTH{1'b0}};
          rsp_err_d   = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          state_d = ST_ACCESS;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight transfer.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= ST_IDLE;
      paddr_q     <= {ADDR_WIDTH{1'b0}};
      pdata_q     <= {DATA_WIDTH{1'b0}};
      pwrite_q    <= 1'b0;
      pstb_q      <= {STB_WIDTH{1'b0}};
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {DATA_WIDTH{1'b0}};
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pdata_q     <= pdata_d;
      pwrite_q    <= pwrite_d;
      pstb_q      <= pstb_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign paddr     = paddr_q;
  assign pdata     = pdata_q;
  assign pwrite    = pwrite_q;
  assign pstb      = pstb_q;
  assign psel      = psel_q;
  assign penable   = penable_q;

endmodule
